// File: rtl/alu_pkg.sv
// Shared opcode, unit, flag and state definitions for the ALU op issuer.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_ASR = 3'd7;

    localparam logic [1:0] U_ADDSUB = 2'd0;
    localparam logic [1:0] U_BIT    = 2'd1;
    localparam logic [1:0] U_SHIFT  = 2'd2;

    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_N = 2;
    localparam int FLG_Z = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [1:0] op_unit(input logic [2:0] op);
        logic [1:0] u;
        case (op)
            OP_ADD, OP_SUB:         u = U_ADDSUB;
            OP_AND, OP_OR, OP_XOR:  u = U_BIT;
            default:                u = U_SHIFT;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/alu_flag_select.sv
// Picks the flag set of the ALU unit that executed the opcode.
module alu_flag_select
    import alu_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      cout,
    input  logic [2:0]      overflow,
    input  logic [2:0]      negative,
    input  logic [2:0]      zero,
    output logic [3:0]      flags
);

    logic [1:0] unit;

    always_comb begin
        unit  = op_unit(op[2:0]);
        flags = '0;
        unique case (unit)
            U_ADDSUB: begin
                flags[FLG_C] = cout[U_ADDSUB];
                flags[FLG_V] = overflow[U_ADDSUB];
                flags[FLG_N] = negative[U_ADDSUB];
                flags[FLG_Z] = zero[U_ADDSUB];
            end
            U_BIT: begin
                flags[FLG_C] = cout[U_BIT];
                flags[FLG_V] = overflow[U_BIT];
                flags[FLG_N] = negative[U_BIT];
                flags[FLG_Z] = zero[U_BIT];
            end
            default: begin
                flags[FLG_C] = cout[U_SHIFT];
                flags[FLG_V] = overflow[U_SHIFT];
                flags[FLG_N] = negative[U_SHIFT];
                flags[FLG_Z] = zero[U_SHIFT];
            end
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Command/response front end for the ALU: issues one op, waits out the
// datapath latency, captures result and flags, returns them over valid/ready.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int OP_W     = 3,
    parameter int WAIT_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [2:0]        alu_cout,
    input  logic [2:0]        alu_overflow,
    input  logic [2:0]        alu_negative,
    input  logic [2:0]        alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OP_W-1:0]   rsp_op,
    output logic [DATA_W-1:0] rsp_c,
    output logic [3:0]        rsp_flags,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam int WC_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(WAIT_CYC - 1);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
    logic [DATA_W-1:0] rsp_c_q, rsp_c_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [3:0]        sel_flags;
    logic              cmd_accept;

    alu_flag_select #(.OP_W(OP_W)) u_flag_sel (
        .op       (alu_op_q),
        .cout     (alu_cout),
        .overflow (alu_overflow),
        .negative (alu_negative),
        .zero     (alu_zero),
        .flags    (sel_flags)
    );

    // Ready also opens in DONE when the response is taken, so a new op
    // can start without a bubble.
    assign cmd_ready  = ~rst & ((state_q == S_IDLE) |
                                ((state_q == S_DONE) & rsp_ready));
    assign cmd_accept = cmd_valid & cmd_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_op_d    = rsp_op_q;
        rsp_c_d     = rsp_c_q;
        rsp_flags_d = rsp_flags_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;

        if (cmd_accept) begin
            alu_op_d = cmd_op;
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = WC_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_op_d    = alu_op_q;
                    rsp_c_d     = alu_c;
                    rsp_flags_d = sel_flags;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - WC_W'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = cmd_accept ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_op_q    <= '0;
            rsp_c_q     <= '0;
            rsp_flags_q <= '0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_op_q    <= rsp_op_d;
            rsp_c_q     <= rsp_c_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule
